// File: rtl/phase_tick_sequencer.sv
// phase_tick_sequencer: four-phase tick-timed sequencer with internal prescaler; define PHASE_SEQ_LOOP_EN for continuous looping.
module phase_tick_sequencer #(
  parameter int DIV = 50_000,
  parameter int DIV_W = 16,
  parameter int DW = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            start_in,
  input  logic            stop_in,
  input  logic [4*DW-1:0] dur_in,
  output logic            tick_out,
  output logic [1:0]      phase_out,
  output logic [3:0]      phase_oh_out,
  output logic [DW-1:0]   remain_out,
  output logic            busy_out,
  output logic            done_out
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
  state_t state;
  logic [DIV_W-1:0] presc;
  logic [DW-1:0] sh [4];
  function automatic logic [DW-1:0] eff(input logic [DW-1:0] d);
    return d == '0 ? DW'(1) : d;
  endfunction
  assign busy_out = state == RUN;
  assign tick_out = busy_out && presc == LAST;
  assign phase_oh_out = busy_out ? 4'b0001 << phase_out : 4'b0000;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      presc <= '0;
      phase_out <= '0;
      remain_out <= '0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (state == IDLE) begin
        if (start_in && !stop_in) begin
          state <= RUN;
          presc <= '0;
          phase_out <= '0;
          remain_out <= eff(dur_in[DW-1:0]);
          for (int k = 0; k < 4; k++) sh[k] <= dur_in[k*DW +: DW];
        end
      end else if (stop_in) begin
        state <= IDLE;
        presc <= '0;
        phase_out <= '0;
        remain_out <= '0;
      end else begin
        presc <= tick_out ? '0 : presc + DIV_W'(1);
        if (tick_out) begin
          if (remain_out > DW'(1)) remain_out <= remain_out - DW'(1);
          else if (phase_out != 2'd3) begin
            phase_out <= phase_out + 2'd1;
            remain_out <= eff(sh[phase_out + 2'd1]);
          end else begin
            done_out <= 1'b1;
`ifdef PHASE_SEQ_LOOP_EN
            phase_out <= '0;
            remain_out <= eff(sh[0]);
`else
            state <= IDLE;
            presc <= '0;
            phase_out <= '0;
            remain_out <= '0;
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_phase_tick_sequencer.sv
// tb_phase_tick_sequencer: directed stimulus with a run-end scoreboard for phase_tick_sequencer (DIV=4, DW=4).
module tb_phase_tick_sequencer;
  localparam int DIV = 4;
  localparam int DW = 4;
  logic clk = 0, rst = 1, start = 0, stop = 0;
  logic [4*DW-1:0] dur = 16'h0312;
  logic tick, busy, done;
  logic [1:0] phase;
  logic [3:0] oh;
  logic [DW-1:0] remain;
  phase_tick_sequencer #(.DIV(DIV), .DIV_W(16), .DW(DW)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop), .dur_in(dur),
    .tick_out(tick), .phase_out(phase), .phase_oh_out(oh), .remain_out(remain),
    .busy_out(busy), .done_out(done)
  );
  always #5 clk = ~clk;
  typedef struct {int len; int ticks; int done; int p0; int p1; int p2; int p3;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int done_q[$];
  int tests = 0, fails = 0, idle_ticks = 0, done_seen = 0;
  int cnt = 0, tk = 0;
  int pl[4] = '{0, 0, 0, 0};
  logic prev_busy = 0;
  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic expect_run(input int len, input int ticks, input int dn, input int p0, input int p1, input int p2, input int p3);
    exp_q.push_back('{len, ticks, dn, p0, p1, p2, p3});
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_run();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
  endtask
  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_oh"}, int'(oh), 0);
    check({tag, "_remain"}, int'(remain), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_tick"}, int'(tick), 0);
  endtask
  // Monitor: accumulates each run and scores it when busy falls
  always @(negedge clk) begin
    if (done) done_seen++;
    if (!busy && tick) idle_ticks++;
    if (busy) begin
      cnt++;
      pl[phase]++;
      if (tick) tk++;
      if (done) begin
        if (done_q.size() == 0) check("unexpected_loop_done", 1, 0);
        else check("loop_done_cycle", cnt, done_q.pop_front());
      end
    end else if (prev_busy) begin
      if (exp_q.size() == 0) check("unexpected_run_end", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("run_len", cnt, e.len);
        check("run_ticks", tk, e.ticks);
        check("run_done", int'(done), e.done);
        check("phase0_len", pl[0], e.p0);
        check("phase1_len", pl[1], e.p1);
        check("phase2_len", pl[2], e.p2);
        check("phase3_len", pl[3], e.p3);
        check("end_oh", int'(oh), 0);
        check("end_remain", int'(remain), 0);
      end
      cnt = 0;
      tk = 0;
      pl = '{0, 0, 0, 0};
    end
    prev_busy = busy;
  end
  initial begin
    idle(3);
    check_reset_values("reset");
    rst = 0;
`ifndef PHASE_SEQ_LOOP_EN
    expect_run(28, 7, 1, 8, 4, 12, 4);
    start_run();
    check("c1_remain", int'(remain), 2);
    check("c1_oh", int'(oh), 1);
    idle(8);
    check("c9_phase", int'(phase), 1);
    check("c9_remain", int'(remain), 1);
    check("c9_oh", int'(oh), 2);
    idle(4);
    check("c13_phase", int'(phase), 2);
    check("c13_remain", int'(remain), 3);
    idle(12);
    check("c25_phase", int'(phase), 3);
    check("c25_remain", int'(remain), 1);
    check("c25_oh", int'(oh), 8);
    idle(8);
    expect_run(18, 4, 0, 8, 4, 6, 0);
    start_run();
    idle(17);
    stop = 1;
    idle(1);
    stop = 0;
    check("stop_busy", int'(busy), 0);
    idle(6);
    check("done_count_after_stop", done_seen, 1);
    expect_run(28, 7, 0, 8, 4, 12, 4);
    start_run();
    idle(27);
    stop = 1;
    idle(1);
    stop = 0;
    idle(6);
    check("done_count_after_final_stop", done_seen, 1);
    start = 1;
    stop = 1;
    idle(1);
    start = 0;
    stop = 0;
    check("start_stop_idle_busy", int'(busy), 0);
    idle(2);
    check("start_stop_idle_busy_later", int'(busy), 0);
    expect_run(28, 7, 1, 8, 4, 12, 4);
    start_run();
    start = 1;
    idle(20);
    start = 0;
    idle(12);
    check("done_count_after_held", done_seen, 2);
    expect_run(28, 7, 1, 8, 4, 12, 4);
    expect_run(16, 4, 1, 4, 4, 4, 4);
    start_run();
    dur = 16'h1111;
    idle(32);
    start_run();
    idle(20);
    check("done_count_after_dur", done_seen, 4);
    dur = 16'h0312;
`else
    done_q.push_back(29);
    done_q.push_back(57);
    done_q.push_back(85);
    expect_run(90, 22, 0, 30, 12, 36, 12);
    start_run();
    idle(89);
    stop = 1;
    idle(1);
    stop = 0;
    idle(4);
    check("loop_done_count", done_seen, 3);
`endif
    expect_run(10, 2, 0, 8, 2, 0, 0);
    start_run();
    idle(9);
    rst = 1;
    idle(1);
    check_reset_values("midrun_reset");
    rst = 0;
    idle(8);
    check("idle_ticks", idle_ticks, 0);
    check("pending_runs", exp_q.size(), 0);
    check("pending_loop_dones", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
